ntt_seq_ctrl: RTL and testbench
===============================

Name: ntt_seq_ctrl

Overview:
Host-side sequencer for the serial NTT engine port (load_w / load_data / start / start_intt / din / done / dout).
- Accepts commands (load twiddles, run NTT, run INTT) plus a valid/ready word stream from a requester.
- Converts them into the engine's cycle-exact pulse-and-stream protocol.
- Captures the RING_SIZE-word result burst after done and forwards it as a valid-only stream.
- Sits between the system interconnect and the NTT top-level.

Parameters:
RING_SIZE, 1024, coefficients per polynomial (power of two, ≥4)
DATA_W, 64, word width (equals CIPHER_SIZE)
GAP_CYCLES, 5, idle cycles after each stream before the next pulse
WDOG_CYCLES, 65536, done-timeout limit (used only with NTT_SEQ_WDOG_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_op  in  2  0=load twiddles, 1=NTT, 2=INTT, 3=reserved
s_valid  in  1  input word valid
s_ready  out  1  controller consuming input word
s_data  in  DATA_W  input word
m_valid  out  1  result word valid (no backpressure)
m_data  out  DATA_W  result word
m_last  out  1  marks result word RING_SIZE-1
busy  out  1  state != IDLE
tw_loaded  out  1  twiddles/modulus loaded since reset
err  out  3  sticky: [0] bad op, [1] input underrun, [2] watchdog
err_clr  in  1  clears err
ntt_load_w  out  1  to engine load_w
ntt_load_data  out  1  to engine load_data
ntt_start  out  1  to engine start
ntt_start_intt  out  1  to engine start_intt
ntt_din  out  DATA_W  to engine din
ntt_done  in  1  from engine done
ntt_dout  in  DATA_W  from engine dout

Behaviour:
- Reset (async, active-high): state IDLE, all outputs 0, counters 0, tw_loaded=0, err=0.
- cmd_ready=1 only in IDLE. On accept:
  - op0 → TW_PULSE.
  - op1/op2 with tw_loaded=1 → D_PULSE; op latched.
  - op1/op2 with tw_loaded=0, or op3 → err[0] set, stay IDLE.
- TW_PULSE (1 cycle): ntt_load_w=1 → TW_STREAM.
- TW_STREAM: s_ready=1; consumes exactly 2*RING_SIZE+1 words (w[0..N-1], wp[0..N-1], q) on consecutive cycles. Each consumed word is driven on ntt_din in the same cycle it is accepted (combinational s_data→ntt_din mux path, registered select). Then → GAP; tw_loaded set on exit.
- GAP: GAP_CYCLES cycles, ntt_din=0 → IDLE (after TW), or → START (after data).
- D_PULSE (1 cycle): ntt_load_data=1 → D_STREAM.
- D_STREAM: s_ready=1 for exactly RING_SIZE cycles → GAP.
- Underrun: the engine cannot stall. If s_valid=0 in a stream cycle, drive 0, set err[1], and still advance the counter. Job continues; result is garbage but framing stays intact.
- START (1 cycle): ntt_start=1 for op1 or ntt_start_intt=1 for op2 → WAIT.
- WAIT: waits for ntt_done=1 → DRAIN.
- DRAIN: on each of the RING_SIZE cycles starting the cycle after done is sampled high, m_valid=1 and m_data=ntt_dout registered (one-cycle latency). m_last on the final word → IDLE.
- Counter width: clog2(2*RING_SIZE+1); it wraps only via explicit reset per state.
- ntt_load_w, ntt_load_data, ntt_start and ntt_start_intt are registered, mutually exclusive, and never high two cycles in a row.
- err_clr clears err the next cycle; a simultaneous new error wins (err bit stays set).
- Reset mid-operation: immediate return to IDLE; tw_loaded cleared (engine must be reloaded).
- cmd_valid is ignored outside IDLE; no queueing.

Optional Feature:
NTT_SEQ_WDOG_EN:
- Defined: WAIT counts cycles. If ntt_done is not seen within WDOG_CYCLES, set err[2], drive no result, and return to IDLE.
- Undefined: WAIT waits forever; err[2] is tied 0.

Test Plan:
1. RING_SIZE=8, op0 with 17 contiguous words 1..17 → ntt_load_w one cycle, ntt_din=1..17 on the next 17 cycles, 5 idle cycles, tw_loaded=1, err=0.
2. op1 before any op0 → err=3'b001, no engine pulse, cmd_ready stays 1; err_clr → err=0.
3. After test 1, op1 with words 0..7, engine model asserts done 20 cycles after start returning 100..107 → ntt_start single pulse after 5-cycle gap; m_data=100..107 contiguous starting 2 cycles after done rises; m_last on 107; busy drops the cycle after.
4. op2 same as test 3 → ntt_start_intt pulses, ntt_start stays 0.
5. op1 with s_valid low on word 3 → ntt_din=0 that cycle, err[1]=1, remaining words keep their positions, result still drained.
6. NTT_SEQ_WDOG_EN, WDOG_CYCLES=32, engine never asserts done → err[2]=1 after 32 WAIT cycles, m_valid never high, IDLE; reset asserted mid-DRAIN in a separate run → all outputs 0 and tw_loaded=0 immediately.

Source files
------------

// File: rtl/ntt_seq_ctrl.sv
// rtl/ntt_seq_ctrl.sv - host-side sequencer for the serial NTT engine pulse/stream port
// Optional done watchdog enabled by defining NTT_SEQ_WDOG_EN (adds parameter WDOG_CYCLES).
module ntt_seq_ctrl #(
  parameter int RING_SIZE  = 1024,
  parameter int DATA_W     = 64,
  parameter int GAP_CYCLES = 5
`ifdef NTT_SEQ_WDOG_EN
  , parameter int WDOG_CYCLES = 65536
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              tw_loaded,
  output logic [2:0]        err,
  input  logic              err_clr,
  output logic              ntt_load_w,
  output logic              ntt_load_data,
  output logic              ntt_start,
  output logic              ntt_start_intt,
  output logic [DATA_W-1:0] ntt_din,
  input  logic              ntt_done,
  input  logic [DATA_W-1:0] ntt_dout
);

  localparam int CNT_W = $clog2(2*RING_SIZE+1);
  localparam logic [CNT_W-1:0] TW_LAST   = CNT_W'(2*RING_SIZE);
  localparam logic [CNT_W-1:0] D_LAST    = CNT_W'(RING_SIZE-1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES-1);
  localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(RING_SIZE);

  typedef enum logic [3:0] {
    S_IDLE, S_TW_PULSE, S_TW_STREAM, S_GAP, S_D_PULSE,
    S_D_STREAM, S_START, S_WAIT, S_DRAIN
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             op_intt, op_intt_nx;
  logic             data_job, data_job_nx;
  logic             tw_loaded_nx;
  logic [2:0]       err_set;
  logic             stream_sel;

`ifdef NTT_SEQ_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES+1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES-1);
  logic [WDOG_W-1:0] wdog_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                wdog_cnt <= '0;
    else if (state != S_WAIT) wdog_cnt <= '0;
    else                      wdog_cnt <= wdog_cnt + 1'b1;
  end
`endif

  assign busy    = (state != S_IDLE);
  assign s_ready = stream_sel;
  // The engine cannot stall, so a missing word is replaced by zero rather than waited for.
  assign ntt_din = (stream_sel && s_valid) ? s_data : '0;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    op_intt_nx   = op_intt;
    data_job_nx  = data_job;
    tw_loaded_nx = tw_loaded;
    err_set      = 3'b000;
    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_op == 2'd0) begin
            state_nx    = S_TW_PULSE;
            data_job_nx = 1'b0;
          end else if (cmd_op != 2'd3 && tw_loaded) begin
            state_nx    = S_D_PULSE;
            data_job_nx = 1'b1;
            op_intt_nx  = (cmd_op == 2'd2);
          end else begin
            err_set[0] = 1'b1;
          end
        end
      end
      S_TW_PULSE: begin
        state_nx = S_TW_STREAM;
        cnt_nx   = '0;
      end
      S_TW_STREAM: begin
        if (!s_valid) err_set[1] = 1'b1;
        if (cnt == TW_LAST) begin
          state_nx     = S_GAP;
          cnt_nx       = '0;
          tw_loaded_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx   = '0;
          state_nx = data_job ? S_START : S_IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_D_PULSE: begin
        state_nx = S_D_STREAM;
        cnt_nx   = '0;
      end
      S_D_STREAM: begin
        if (!s_valid) err_set[1] = 1'b1;
        if (cnt == D_LAST) begin
          state_nx = S_GAP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_START: begin
        state_nx = S_WAIT;
        cnt_nx   = '0;
      end
      S_WAIT: begin
        cnt_nx = '0;
        if (ntt_done) begin
          state_nx = S_DRAIN;
        end
`ifdef NTT_SEQ_WDOG_EN
        else if (wdog_cnt == WDOG_LAST) begin
          err_set[2] = 1'b1;
          state_nx   = S_IDLE;
        end
`endif
      end
      S_DRAIN: begin
        // One extra cycle after the last capture so busy stays high while m_last is shown.
        if (m_last) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (cnt != DRAIN_END) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      op_intt        <= 1'b0;
      data_job       <= 1'b0;
      tw_loaded      <= 1'b0;
      err            <= 3'b000;
      cmd_ready      <= 1'b0;
      stream_sel     <= 1'b0;
      ntt_load_w     <= 1'b0;
      ntt_load_data  <= 1'b0;
      ntt_start      <= 1'b0;
      ntt_start_intt <= 1'b0;
      m_valid        <= 1'b0;
      m_data         <= '0;
      m_last         <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      op_intt        <= op_intt_nx;
      data_job       <= data_job_nx;
      tw_loaded      <= tw_loaded_nx;
      err            <= (err & ~{3{err_clr}}) | err_set;
      cmd_ready      <= (state_nx == S_IDLE);
      stream_sel     <= (state_nx == S_TW_STREAM) || (state_nx == S_D_STREAM);
      ntt_load_w     <= (state_nx == S_TW_PULSE);
      ntt_load_data  <= (state_nx == S_D_PULSE);
      ntt_start      <= (state_nx == S_START) && !op_intt_nx;
      ntt_start_intt <= (state_nx == S_START) && op_intt_nx;
      m_valid        <= (state == S_DRAIN) && (cnt != DRAIN_END);
      m_data         <= ((state == S_DRAIN) && (cnt != DRAIN_END)) ? ntt_dout : '0;
      m_last         <= (state == S_DRAIN) && (cnt == D_LAST);
    end
  end

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// tb/tb_ntt_seq_ctrl.sv - scoreboard bench for ntt_seq_ctrl with a behavioural engine model
module tb_ntt_seq_ctrl;
  localparam int N   = 8;
  localparam int GAP = 5;
`ifdef NTT_SEQ_WDOG_EN
  localparam int WD  = 32;
`endif

  logic clk, reset;
  logic cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic s_valid, s_ready;
  logic [63:0] s_data;
  logic m_valid, m_last, busy, tw_loaded, err_clr;
  logic [63:0] m_data;
  logic [2:0] err;
  logic ntt_load_w, ntt_load_data, ntt_start, ntt_start_intt, ntt_done;
  logic [63:0] ntt_din, ntt_dout;

  ntt_seq_ctrl #(
    .RING_SIZE(N), .DATA_W(64), .GAP_CYCLES(GAP)
`ifdef NTT_SEQ_WDOG_EN
    , .WDOG_CYCLES(WD)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .busy(busy), .tw_loaded(tw_loaded), .err(err), .err_clr(err_clr),
    .ntt_load_w(ntt_load_w), .ntt_load_data(ntt_load_data),
    .ntt_start(ntt_start), .ntt_start_intt(ntt_start_intt),
    .ntt_din(ntt_din), .ntt_done(ntt_done), .ntt_dout(ntt_dout)
  );

  typedef struct { logic [63:0] d; logic l; } mexp_t;
  logic [63:0] exp_din[$];
  logic [3:0]  exp_pulse[$];
  mexp_t       exp_m[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, last_stream_cyc = 0, eng_done_cyc = 0, start_cyc = 0;
  bit eng_hang = 0;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bad(input string name, input logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Engine model: done 20 cycles after a start pulse, then N result words on consecutive cycles.
  initial begin
    ntt_done = 0;
    ntt_dout = 0;
    forever begin
      @(negedge clk);
      if ((ntt_start || ntt_start_intt) && !eng_hang) begin
        repeat (20) @(posedge clk);
        #1 ntt_done = 1;
        eng_done_cyc = cyc;
        @(posedge clk);
        #1 ntt_done = 0;
        for (int i = 0; i < N; i++) begin
          ntt_dout = 64'(100 + i);
          @(posedge clk);
          #1;
        end
        ntt_dout = 0;
      end
    end
  end

  logic [3:0] code, prev_code;
  bit prev_mv, busy_check;
  mexp_t e;
  always @(negedge clk) begin
    if (reset) begin
      prev_code = 0; prev_mv = 0; busy_check = 0;
    end else begin
      if (s_ready) begin
        last_stream_cyc = cyc;
        if (exp_din.size() == 0) bad("din_unexpected", ntt_din);
        else chk("ntt_din", ntt_din, exp_din.pop_front());
      end else if (busy) begin
        chk("din_zero_outside_stream", ntt_din, 64'd0);
      end
      code = {ntt_load_w, ntt_load_data, ntt_start, ntt_start_intt};
      if (code != 0) begin
        chk("pulse_onehot", 64'($countones(code)), 64'd1);
        chk("pulse_back_to_back", 64'(prev_code), 64'd0);
        if (exp_pulse.size() == 0) bad("pulse_unexpected", 64'(code));
        else chk("pulse_kind", 64'(code), 64'(exp_pulse.pop_front()));
        if (ntt_start || ntt_start_intt) begin
          start_cyc = cyc;
          chk("start_gap", 64'(cyc - last_stream_cyc), 64'(GAP + 1));
        end
      end
      prev_code = code;
      if (busy_check) begin
        chk("busy_after_last", 64'(busy), 64'd0);
        busy_check = 0;
      end
      if (m_valid) begin
        if (!prev_mv) chk("drain_latency", 64'(cyc - eng_done_cyc), 64'd2);
        if (exp_m.size() == 0) bad("m_unexpected", m_data);
        else begin
          e = exp_m.pop_front();
          chk("m_data", m_data, e.d);
          chk("m_last", 64'(m_last), 64'(e.l));
        end
        if (m_last) begin
          chk("busy_at_last", 64'(busy), 64'd1);
          busy_check = 1;
        end
      end else if (m_last) begin
        bad("m_last_without_valid", 64'(m_last));
      end
      prev_mv = m_valid;
    end
  end

  task automatic push_job(input int op, input int base, input int skip);
    if (op == 0) begin
      exp_pulse.push_back(4'b1000);
      for (int i = 0; i < 2*N+1; i++) exp_din.push_back(64'(base + i));
    end else begin
      exp_pulse.push_back(4'b0100);
      exp_pulse.push_back(op == 2 ? 4'b0001 : 4'b0010);
      for (int i = 0; i < N; i++) exp_din.push_back(i == skip ? 64'd0 : 64'(base + i));
      if (!eng_hang)
        for (int i = 0; i < N; i++) exp_m.push_back('{d: 64'(100 + i), l: (i == N-1)});
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic clr);
    int k;
    k = 0;
    @(posedge clk);
    #1 cmd_valid = 1; cmd_op = op; err_clr = clr;
    while (k < 50) begin
      @(negedge clk);
      if (cmd_ready) break;
      k++;
    end
    if (!cmd_ready) bad("cmd_ready_timeout", 64'(k));
    @(posedge clk);
    #1 cmd_valid = 0; err_clr = 0;
  endtask

  task automatic drive_stream(input int n, input int base, input int skip);
    int k;
    k = 0;
    while (k < 50) begin
      @(posedge clk);
      #1;
      if (s_ready) break;
      k++;
    end
    if (!s_ready) bad("s_ready_timeout", 64'(k));
    for (int i = 0; i < n; i++) begin
      s_valid = (i != skip);
      s_data  = (i != skip) ? 64'(base + i) : 64'hDEAD_BEEF;
      @(posedge clk);
      #1;
    end
    s_valid = 0;
    s_data  = 0;
  endtask

  task automatic wait_idle(output int at);
    int k;
    k  = 0;
    at = -1;
    while (k < 400) begin
      @(negedge clk);
      if (!busy) begin
        at = cyc;
        break;
      end
      k++;
    end
    if (at < 0) bad("idle_timeout", 64'(k));
  endtask

  task automatic clear_err();
    @(posedge clk);
    #1 err_clr = 1;
    @(posedge clk);
    #1 err_clr = 0;
    chk("err_cleared", 64'(err), 64'd0);
  endtask

  int t0, t1;
  initial begin
    reset = 1; cmd_valid = 0; cmd_op = 0; s_valid = 0; s_data = 0; err_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {cmd_ready, s_ready, m_valid, m_last, busy, tw_loaded,
                        ntt_load_w, ntt_load_data, ntt_start, ntt_start_intt}, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_din", ntt_din, 64'd0);
    @(negedge clk);
    #1 reset = 0;
    @(posedge clk);
    #1 chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);

    // bad ops: reserved op3, then op1 without twiddles with a simultaneous err_clr
    send_cmd(2'd3, 1'b0);
    chk("err_op3", 64'(err), 64'b001);
    chk("op3_stays_idle", {cmd_ready, busy}, 64'b10);
    send_cmd(2'd1, 1'b1);
    chk("err_set_beats_clr", 64'(err), 64'b001);
    chk("op1_no_tw_idle", {cmd_ready, busy}, 64'b10);
    clear_err();

    // load twiddles: 17 words 1..17
    push_job(0, 1, -1);
    send_cmd(2'd0, 1'b0);
    drive_stream(2*N+1, 1, -1);
    t0 = cyc;
    wait_idle(t1);
    chk("tw_gap_len", 64'(t1 - t0), 64'(GAP));
    chk("tw_loaded_set", 64'(tw_loaded), 64'd1);
    chk("tw_err", 64'(err), 64'd0);

    // forward NTT, then INTT
    push_job(1, 0, -1);
    send_cmd(2'd1, 1'b0);
    drive_stream(N, 0, -1);
    wait_idle(t1);
    chk("ntt_err", 64'(err), 64'd0);
    push_job(2, 20, -1);
    send_cmd(2'd2, 1'b0);
    drive_stream(N, 20, -1);
    wait_idle(t1);
    chk("intt_err", 64'(err), 64'd0);

    // underrun on word 3
    push_job(1, 10, 3);
    send_cmd(2'd1, 1'b0);
    drive_stream(N, 10, 3);
    wait_idle(t1);
    chk("underrun_err", 64'(err), 64'b010);
    clear_err();

    // reset in the middle of the result burst
    push_job(1, 40, -1);
    send_cmd(2'd1, 1'b0);
    drive_stream(N, 40, -1);
    t0 = 0;
    while (t0 < 100 && !m_valid) begin
      @(negedge clk);
      t0++;
    end
    if (!m_valid) bad("drain_timeout", 64'(t0));
    repeat (2) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("midrst_outputs", {cmd_ready, s_ready, m_valid, m_last, busy, tw_loaded,
                           ntt_load_w, ntt_load_data, ntt_start, ntt_start_intt}, 64'd0);
    chk("midrst_m_data", m_data, 64'd0);
    exp_m.delete();
    @(negedge clk);
    #1 reset = 0;
    @(posedge clk);
    #1 chk("midrst_tw_cleared", {cmd_ready, tw_loaded}, 64'b10);
    send_cmd(2'd1, 1'b0);
    chk("midrst_needs_reload", 64'(err), 64'b001);
    clear_err();

`ifdef NTT_SEQ_WDOG_EN
    push_job(0, 1, -1);
    send_cmd(2'd0, 1'b0);
    drive_stream(2*N+1, 1, -1);
    wait_idle(t1);
    eng_hang = 1;
    push_job(1, 0, -1);
    send_cmd(2'd1, 1'b0);
    drive_stream(N, 0, -1);
    wait_idle(t1);
    chk("wdog_wait_len", 64'(t1 - start_cyc), 64'(WD + 1));
    chk("wdog_err", 64'(err), 64'b100);
    clear_err();
    eng_hang = 0;
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("din_queue_empty", 64'(exp_din.size()), 64'd0);
    chk("pulse_queue_empty", 64'(exp_pulse.size()), 64'd0);
    chk("m_queue_empty", 64'(exp_m.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
